// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU bus definitions: response-owner encoding and the boot-ROM alias remap constants.
package mem_port_arbiter_pkg;

  typedef logic [0:0] rsp_owner_t;

  localparam rsp_owner_t RSP_I = 1'b0;
  localparam rsp_owner_t RSP_D = 1'b1;

  // Upper address half that aliases into physical memory, and its physical replacement.
  localparam logic [15:0] REMAP_FROM = 16'hbfaf;
  localparam logic [15:0] REMAP_TO   = 16'h1faf;

endpackage

// File: rtl/mem_port_arbiter_addr_remap.sv
// Combinational address remap: the aliased upper half is rewritten, every other address passes through.
module addr_remap
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] remapped
);

  always_comb begin
    remapped = addr;
    if (addr[ADDR_W-1 -: 16] == REMAP_FROM) begin
      remapped[ADDR_W-1 -: 16] = REMAP_TO;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port SRAM (1-cycle read latency); data wins
// except when fetch has waited MAX_D_STREAK consecutive data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [ADDR_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] d_rdata,

  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,

  output logic              i_stall,
  output logic              d_stall
);

  localparam int            SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(MAX_D_STREAK);

  logic [SW-1:0]     d_streak;
  logic              rsp_vld;
  rsp_owner_t        rsp_owner;
  logic [ADDR_W-1:0] i_rdata_q;
  logic [ADDR_W-1:0] d_rdata_q;
  logic [ADDR_W-1:0] win_addr;
  logic              starve;

  // Fetch has watched a full streak of data grants: it takes this cycle.
  assign starve = i_req && (d_streak == STREAK_SAT);

  assign d_gnt  = !rst && d_req && !starve;
  assign i_gnt  = !rst && i_req && !d_gnt;
  assign mem_en = i_gnt || d_gnt;

  assign mem_wen   = d_gnt ? d_wen : 4'b0000;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign win_addr  = d_gnt ? d_addr : i_addr;

  addr_remap #(
    .ADDR_W(ADDR_W)
  ) u_addr_remap (
    .addr    (win_addr),
    .remapped(mem_addr)
  );

  assign i_stall = i_req && !i_gnt;
  assign d_stall = d_req && !d_gnt;

  // A grant issued just before reset rises never produces a response.
  assign i_rvalid = rsp_vld && !rst && (rsp_owner == RSP_I);
  assign d_rvalid = rsp_vld && !rst && (rsp_owner == RSP_D);

  // The owner sees SRAM data in its response cycle; the other port keeps its last value.
  assign i_rdata = i_rvalid ? mem_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld   <= 1'b0;
      rsp_owner <= RSP_I;
      d_streak  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      rsp_vld <= mem_en;
      if (mem_en) begin
        rsp_owner <= d_gnt ? RSP_D : RSP_I;
      end
      if (i_rvalid) begin
        i_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
      if (!i_req || i_gnt) begin
        d_streak <= '0;
      end else if (d_gnt && (d_streak != STREAK_SAT)) begin
        d_streak <= d_streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table, corner-case sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int NV   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_gnt, d_rvalid;
  logic [3:0]  d_wen;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        i_stall, d_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .i_stall(i_stall), .d_stall(d_stall)
  );

  typedef struct {
    logic        rst, ir, dr;
    logic [3:0]  wen;
    logic [31:0] ia, da, wd, rd;
    logic        e_ig, e_dg, e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic        e_irv, e_drv;
    logic [31:0] e_ird, e_drd;
    logic        e_chkd;
  } vec_t;

  vec_t vec [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
  task automatic drive(input logic r, input logic ir, input logic dr, input logic [3:0] w,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r; i_req = ir; d_req = dr; d_wen = w;
    i_addr = ia; d_addr = da; d_wdata = wd; mem_rdata = rd;
    #3;
  endtask

  function automatic logic [31:0] remap_m(input logic [31:0] a);
    logic [31:0] r;
    r = a;
    if (a[31:16] == 16'hbfaf) r = {16'h1faf, a[15:0]};
    return r;
  endfunction

  // Transaction-level model state
  int          m_streak;
  logic        m_pv, m_pd, m_pw, m_dknown;
  logic [31:0] m_ih, m_dh;

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 4'h0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    //        rst ir dr wen  i_addr        d_addr        d_wdata       mem_rdata      ig dg en wen  addr          irv drv i_rdata       d_rdata       chkd
    vec[0] = '{1, 1, 1, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        32'h0,        1};
    vec[1] = '{0, 1, 0, 4'h0, 32'hbfc00000, 32'h0,        32'h0,        32'h11111111,  1, 0, 1, 4'h0, 32'hbfc00000, 0, 0, 32'h0,        32'h0,        1};
    vec[2] = '{0, 1, 0, 4'h0, 32'hbfc00000, 32'h0,        32'h0,        32'h22222222,  1, 0, 1, 4'h0, 32'hbfc00000, 1, 0, 32'h22222222, 32'h0,        1};
    vec[3] = '{0, 1, 0, 4'h0, 32'hbfc00000, 32'h0,        32'h0,        32'h33333333,  1, 0, 1, 4'h0, 32'hbfc00000, 1, 0, 32'h33333333, 32'h0,        1};
    vec[4] = '{0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h44444444,  0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h44444444, 32'h0,        1};
    vec[5] = '{0, 1, 1, 4'h0, 32'hbfc00010, 32'hbfaf8000, 32'h0,        32'h55555555,  0, 1, 1, 4'h0, 32'h1faf8000, 0, 0, 32'h44444444, 32'h0,        1};
    vec[6] = '{0, 0, 1, 4'h3, 32'h0,        32'h00001000, 32'h1234abcd, 32'h66666666,  0, 1, 1, 4'h3, 32'h00001000, 0, 1, 32'h44444444, 32'h66666666, 1};
    vec[7] = '{0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h77777777,  0, 0, 0, 4'h0, 32'h0,        0, 1, 32'h44444444, 32'h0,        0};
    vec[8] = '{0, 1, 0, 4'h0, 32'hbfaf0004, 32'h0,        32'h0,        32'h88888888,  1, 0, 1, 4'h0, 32'h1faf0004, 0, 0, 32'h44444444, 32'h0,        0};
    vec[9] = '{0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h99999999,  0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h99999999, 32'h0,        0};

    repeat (2) drive(1, 0, 0, 4'h0, 0, 0, 0, 0);

    for (int k = 0; k < NV; k++) begin
      drive(vec[k].rst, vec[k].ir, vec[k].dr, vec[k].wen, vec[k].ia, vec[k].da, vec[k].wd, vec[k].rd);
      chk($sformatf("vec%0d ctrl", k),
          {i_gnt, d_gnt, mem_en, mem_wen, i_rvalid, d_rvalid, i_stall, d_stall},
          {vec[k].e_ig, vec[k].e_dg, vec[k].e_en, vec[k].e_wen, vec[k].e_irv, vec[k].e_drv,
           vec[k].ir & ~vec[k].e_ig, vec[k].dr & ~vec[k].e_dg});
      if (vec[k].e_en) chk($sformatf("vec%0d mem_addr", k), mem_addr, vec[k].e_addr);
      if (vec[k].e_dg) chk($sformatf("vec%0d mem_wdata", k), mem_wdata, vec[k].wd);
      chk($sformatf("vec%0d i_rdata", k), i_rdata, vec[k].e_ird);
      if (vec[k].e_chkd) chk($sformatf("vec%0d d_rdata", k), d_rdata, vec[k].e_drd);
    end

    // Starvation: both held for 6 cycles -> D D D D I D
    for (int c = 1; c <= 6; c++) begin
      drive(0, 1, 1, 4'h0, 32'h100, 32'h200 + c, 0, $urandom);
      chk($sformatf("starve c%0d gnt", c), {i_gnt, d_gnt}, (c == 5) ? 2'b10 : 2'b01);
    end

    // Dropped data request while the streak is saturated
    drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, 1, 4'h0, 32'h300, 32'h400, 0, 0);
      chk($sformatf("sat c%0d d_gnt", c), d_gnt, 1'b1);
    end
    drive(0, 1, 1, 4'h0, 32'h300, 32'h500, 0, 0);
    chk("drop pulse gnt", {i_gnt, d_gnt}, 2'b10);
    drive(0, 1, 0, 4'h0, 32'h304, 0, 0, 0);
    chk("drop after d_gnt/d_rvalid", {d_gnt, d_rvalid}, 2'b00);
    drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
    chk("drop tail rvalid", {i_rvalid, d_rvalid}, 2'b10);

    // Reset arriving the cycle after a grant
    drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
    drive(0, 1, 1, 4'h0, 32'h600, 32'h700, 0, 32'hdeadbeef);
    chk("rstmid grant", d_gnt, 1'b1);
    drive(1, 1, 1, 4'hf, 32'h600, 32'h700, 32'h5, 32'hcafef00d);
    chk("rstmid outputs in rst", {i_gnt, d_gnt, mem_en, mem_wen, i_rvalid, d_rvalid}, 9'h0);
    drive(0, 0, 0, 4'h0, 0, 0, 0, 32'h12345678);
    chk("rstmid d_streak", dut.d_streak, 3'd0);
    chk("rstmid rvalid after", {i_rvalid, d_rvalid}, 2'b00);
    chk("rstmid rdata cleared", {i_rdata, d_rdata}, 64'h0);

    // Randomized run against the transaction-level model
    m_streak = 0; m_pv = 0; m_pd = 0; m_pw = 0; m_dknown = 1; m_ih = '0; m_dh = '0;
    for (int n = 0; n < 1500; n++) begin
      logic        r, ir, dr, gi, gd, erv_i, erv_d;
      logic [3:0]  w;
      logic [31:0] ia, da, wd, rd, e_ird, e_drd;
      r  = ($urandom_range(0, 39) == 0);
      ir = $urandom_range(0, 1) != 0;
      dr = $urandom_range(0, 1) != 0;
      w  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      ia = $urandom; da = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 3) == 0) ia[31:16] = 16'hbfaf;
      if ($urandom_range(0, 3) == 0) da[31:16] = 16'hbfaf;
      drive(r, ir, dr, w, ia, da, wd, rd);

      gd    = !r && dr && !(ir && m_streak == MAXS);
      gi    = !r && ir && !gd;
      erv_i = !r && m_pv && !m_pd;
      erv_d = !r && m_pv && m_pd;
      e_ird = erv_i ? rd : m_ih;
      e_drd = erv_d ? rd : m_dh;

      chk($sformatf("rnd%0d ctrl", n),
          {i_gnt, d_gnt, mem_en, mem_wen, i_rvalid, d_rvalid, i_stall, d_stall},
          {gi, gd, gi | gd, gd ? w : 4'h0, erv_i, erv_d, ir & ~gi, dr & ~gd});
      if (gi || gd) chk($sformatf("rnd%0d mem_addr", n), mem_addr, remap_m(gd ? da : ia));
      if (gd) chk($sformatf("rnd%0d mem_wdata", n), mem_wdata, wd);
      chk($sformatf("rnd%0d i_rdata", n), i_rdata, e_ird);
      if (erv_d ? !m_pw : m_dknown) chk($sformatf("rnd%0d d_rdata", n), d_rdata, e_drd);

      if (r) begin
        m_streak = 0; m_pv = 0; m_ih = '0; m_dh = '0; m_dknown = 1;
      end else begin
        if (erv_i) m_ih = rd;
        if (erv_d) begin
          m_dh = rd;
          m_dknown = !m_pw;
        end
        m_pv = gi || gd;
        m_pd = gd;
        m_pw = gd && (w != 4'h0);
        if (!ir || gi) m_streak = 0;
        else if (gd && m_streak < MAXS) m_streak = m_streak + 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address/data width of all ports.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4, meaning consecutive data grants allowed while an instruction request is waiting.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: i_req  in  1  fetch request; i_addr  in  32  fetch address; i_gnt  out  1  fetch accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  32  fetch data.
REQ-005 SHALL have ports: d_req  in  1  data request; d_wen  in  4  byte write enables (0 = read); d_addr  in  32  data address; d_wdata  in  32  write data; d_gnt  out  1  data accepted; d_rvalid  out  1  read data or write ack valid; d_rdata  out  32  read data.
REQ-006 SHALL have ports: mem_en  out  1; mem_wen  out  4; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32, for a single-port SRAM with 1-cycle read latency.
REQ-007 SHALL have ports: i_stall  out  1 (i_req & ~i_gnt); d_stall  out  1 (d_req & ~d_gnt).

Function
REQ-010 SHALL grant at most one requester per cycle; the grant is combinational from req and internal state.
REQ-011 SHALL grant data when d_req is high, except in the case given by REQ-012.
REQ-012 SHALL grant fetch when i_req is high and d_streak == MAX_D_STREAK (anti-starvation).
REQ-013 SHALL grant fetch when only i_req is high; with no request, mem_en SHALL be 0.
REQ-014 SHALL drive mem_en=1 in the granted cycle. mem_addr, mem_wen and mem_wdata SHALL come from the winner. mem_wen SHALL be 0 for a fetch grant.
REQ-015 SHALL remap addresses so that addr[31:16]==16'hbfaf becomes {16'h1faf, addr[15:0]}. All other addresses pass unchanged.
REQ-016 SHALL register the owner of each grant in a 2-state FSM {RSP_I, RSP_D} plus a valid bit.
REQ-017 SHALL assert exactly one of i_rvalid or d_rvalid in cycle N+1 for a grant in cycle N.
REQ-018 SHALL route mem_rdata to the owner's rdata in that cycle. The other rdata SHALL hold its last value.
REQ-019 SHALL assert d_rvalid for writes too (write ack). d_rdata is don't-care for a write ack.
REQ-020 SHALL support a new grant every cycle: grants are back-to-back pipelined and need no idle cycle.
REQ-021 SHALL update d_streak as follows:
- increment, saturating at MAX_D_STREAK, on a data grant while i_req is high;
- clear on any fetch grant;
- clear on any cycle where i_req is low.
REQ-022 SHALL give REQ-012 precedence when both requests are high and the streak is saturated. The data request is stalled for that one cycle.
REQ-023 SHALL treat requesters as holding req/addr/wdata stable until gnt. A request dropped before gnt SHALL be discarded silently.
REQ-024 SHALL keep both streak and owner state consistent when the same cycle has a grant and a response.

Reset
REQ-030 SHALL, while rst is high at a clock edge:
- clear the response-valid bit, d_streak, and i_rdata/d_rdata (to 0);
- set the FSM to RSP_I.
REQ-031 SHALL force i_gnt, d_gnt, mem_en and mem_wen to 0 during any cycle where rst is high.
REQ-032 SHALL drop any grant issued in the cycle before rst rises: no rvalid appears after reset.

Structure
REQ-040 SHALL place the owner-state encoding and the 16'hbfaf/16'h1faf remap constants in a shared CPU bus package.
REQ-041 SHALL implement REQ-015 as one sub-module, addr_remap, instantiated once on the muxed address.
REQ-042 SHALL use a 3-bit streak counter at the default MAX_D_STREAK, and $clog2(MAX_D_STREAK+1) bits in general.

Verification
REQ-050 Fetch only:
- stimulus: i_req=1, i_addr=0xbfc00000 for 3 cycles;
- response: i_gnt=1 each cycle; mem_addr=0xbfc00000; i_rvalid on cycles 2–4 with mem_rdata.
REQ-051 Conflict:
- stimulus: i_req=d_req=1; d_wen=0; d_addr=0xbfaf8000;
- response: d_gnt=1; i_stall=1; mem_addr=0x1faf8000; d_rvalid next cycle.
REQ-052 Starvation:
- stimulus: both requests held high for 6 cycles;
- response: data granted in cycles 1–4, fetch in cycle 5, data in cycle 6.
REQ-053 Write:
- stimulus: d_req=1, d_wen=4'b0011, d_wdata=0x1234abcd;
- response: mem_wen=4'b0011, mem_wdata=0x1234abcd; d_rvalid=1 next cycle; i_rvalid=0.
REQ-054 Reset mid-stream:
- stimulus: grant in cycle N, rst=1 in cycle N+1;
- response: no rvalid in cycle N+1; d_streak=0; mem_en=0 while rst is high.
REQ-055 Dropped request:
- stimulus: d_req pulses for one cycle while the streak is saturated and i_req=1;
- response: d_gnt never asserted; no d_rvalid.
